// File: rtl/mul_div_unit_pkg.sv
// Shared operation codes, FSM state encoding and op-decoding helpers for
// the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam logic [2:0] MDU_OP_NOP   = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // True for the multi-cycle arithmetic ops (MULT/MULTU/DIV/DIVU).
    function automatic logic op_is_arith(input logic [2:0] op);
        logic r;
        case (op)
            MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: r = 1'b1;
            default:                                            r = 1'b0;
        endcase
        return r;
    endfunction

    // True for ops that run the restoring-division datapath.
    function automatic logic op_is_div(input logic [2:0] op);
        logic r;
        case (op)
            MDU_OP_DIV, MDU_OP_DIVU: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    // True for ops that interpret operands as two's complement.
    function automatic logic op_is_signed(input logic [2:0] op);
        logic r;
        case (op)
            MDU_OP_MULT, MDU_OP_DIV: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_div_unit_iter_step.sv
// One combinational iteration of the MDU datapath: shift-add for multiply,
// trial-subtract (restoring) for divide, chosen by div_mode_i.
module mul_div_unit_iter_step #(
    parameter int W = 32
) (
    input  logic         div_mode_i,
    input  logic [W-1:0] acc_hi_i,   // MUL: upper product half / DIV: partial remainder
    input  logic [W-1:0] acc_lo_i,   // MUL: lower product + multiplier / DIV: dividend -> quotient
    input  logic [W-1:0] opnd_i,     // MUL: multiplicand / DIV: divisor
    output logic [W-1:0] acc_hi_o,
    output logic [W-1:0] acc_lo_o
);

    logic [W:0]   sum_s;
    logic [W:0]   shifted_s;
    logic         fits_s;
    logic [W-1:0] diff_s;

    // Compute both candidate iterations and select by mode.
    always_comb begin
        sum_s     = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : {(W+1){1'b0}});
        shifted_s = {acc_hi_i, acc_lo_i[W-1]};
        fits_s    = (shifted_s >= {1'b0, opnd_i});
        // When the divisor fits, the true difference is below 2^W, so W bits suffice.
        diff_s    = shifted_s[W-1:0] - opnd_i;
        if (div_mode_i) begin
            acc_hi_o = fits_s ? diff_s : shifted_s[W-1:0];
            acc_lo_o = {acc_lo_i[W-2:0], fits_s};
        end else begin
            acc_hi_o = sum_s[W:1];
            acc_lo_o = {sum_s[0], acc_lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Flow: IDLE -> PREP (magnitudes) -> CALC (WORD_WIDTH iterations) -> FIX (signs, write HI/LO).
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [WORD_WIDTH-1:0] inA,
    input  logic [WORD_WIDTH-1:0] inB,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] hi,
    output logic [WORD_WIDTH-1:0] lo
);

    localparam int W     = WORD_WIDTH;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    // Two's-complement negate when n is set.
    function automatic logic [W-1:0] neg_if(input logic n, input logic [W-1:0] v);
        return n ? ({W{1'b0}} - v) : v;
    endfunction

    mdu_state_e       state_q;
    logic             busy_q, done_q;
    logic [W-1:0]     hi_q, lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     acc_hi_q, acc_lo_q, opnd_q;
    logic             div_q, signed_q, sa_q, sb_q;

    logic             sa_s, sb_s;
    logic [W-1:0]     mag_a_s, mag_b_s;
    logic [2*W-1:0]   prod_s;
    logic [W-1:0]     acc_hi_d, acc_lo_d;

    mul_div_unit_iter_step #(.W(W)) u_step (
        .div_mode_i (div_q),
        .acc_hi_i   (acc_hi_q),
        .acc_lo_i   (acc_lo_q),
        .opnd_i     (opnd_q),
        .acc_hi_o   (acc_hi_d),
        .acc_lo_o   (acc_lo_d)
    );

    // Operand signs/magnitudes (meaningful in PREP) and signed product (meaningful in FIX).
    always_comb begin
        sa_s    = signed_q & acc_lo_q[W-1];
        sb_s    = signed_q & opnd_q[W-1];
        mag_a_s = neg_if(sa_s, acc_lo_q);
        mag_b_s = neg_if(sb_s, opnd_q);
        if (sa_q ^ sb_q) begin
            prod_s = {(2*W){1'b0}} - {acc_hi_q, acc_lo_q};
        end else begin
            prod_s = {acc_hi_q, acc_lo_q};
        end
    end

    // Control FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= {W{1'b0}};
            lo_q     <= {W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            acc_hi_q <= {W{1'b0}};
            acc_lo_q <= {W{1'b0}};
            opnd_q   <= {W{1'b0}};
            div_q    <= 1'b0;
            signed_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // cancel beats a simultaneous start; otherwise accept new work.
                    if (!cancel && start) begin
                        if (op_is_arith(op)) begin
                            acc_lo_q <= inA;
                            opnd_q   <= inB;
                            div_q    <= op_is_div(op);
                            signed_q <= op_is_signed(op);
                            busy_q   <= 1'b1;
                            state_q  <= ST_PREP;
                        end else if (op == MDU_OP_MTHI) begin
                            hi_q <= inA;
                        end else if (op == MDU_OP_MTLO) begin
                            lo_q <= inA;
                        end else begin
                            busy_q <= 1'b0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_PREP: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        sa_q     <= sa_s;
                        sb_q     <= sb_s;
                        acc_hi_q <= {W{1'b0}};
                        // MUL: multiplier rides in acc_lo; DIV: dividend does.
                        acc_lo_q <= div_q ? mag_a_s : mag_b_s;
                        opnd_q   <= div_q ? mag_b_s : mag_a_s;
                        cnt_q    <= {CNT_W{1'b0}};
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= ST_IDLE;
                    end else begin
                        acc_hi_q <= acc_hi_d;
                        acc_lo_q <= acc_lo_d;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= {CNT_W{1'b0}};
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_FIX: begin
                    if (cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        if (div_q) begin
                            // Quotient sign from sA^sB; remainder follows the dividend.
                            lo_q <= neg_if(sa_q ^ sb_q, acc_lo_q);
                            hi_q <= neg_if(sa_q, acc_hi_q);
                        end else begin
                            hi_q <= prod_s[2*W-1:W];
                            lo_q <= prod_s[W-1:0];
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (WORD_WIDTH=32): expected HI/LO are
// pushed when an op is issued and popped when done pulses.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [2:0]  op;
    logic [31:0] inA, inB;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb_q[$];
    logic [31:0] m_hi, m_lo;
    int          checks   = 0;
    int          failures = 0;

    mul_div_unit #(.WORD_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .inA(inA), .inB(inB),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from native 64-bit / integer arithmetic.
    function automatic res_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [63:0] p;
        int          sa, sbv;
        r.hi = m_hi;
        r.lo = m_lo;
        sa   = a;
        sbv  = b;
        case (o)
            MDU_OP_MULT: begin
                p = longint'(sa) * longint'(sbv);
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            MDU_OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            MDU_OP_DIV: begin
                if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.hi = 32'd0; r.lo = 32'h8000_0000; end
                else begin r.lo = sa / sbv; r.hi = sa % sbv; end
            end
            MDU_OP_DIVU: begin
                if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
                else begin r.lo = a / b; r.hi = a % b; end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Issue an arithmetic op at a negedge and track it to completion.
    // poke_at/cancel_at/rst_at are cycle offsets after acceptance (-1 = unused).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int cancel_at, input int rst_at);
        res_t e;
        res_t r;
        int   cyc;
        bit   busy_bad;
        bit   seen;
        bit   expect_done;
        e = model(o, a, b);
        expect_done = (cancel_at < 0) && (rst_at < 0);
        if (expect_done) sb_q.push_back(e);
        start = 1'b1; op = o; inA = a; inB = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; busy_bad = 1'b0; seen = 1'b0;
        while (cyc < 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            if (cyc == cancel_at) begin
                cancel = 1'b1;
                @(negedge clk);
                cancel = 1'b0;
                check_val("cancel_busy", busy, 0);
                check_val("cancel_done", done, 0);
                check_val("cancel_hi", hi, m_hi);
                check_val("cancel_lo", lo, m_lo);
                return;
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check_val("rst_busy", busy, 0);
                check_val("rst_hi", hi, 0);
                check_val("rst_lo", lo, 0);
                m_hi = 32'd0; m_lo = 32'd0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            start = (cyc == poke_at);
            op    = MDU_OP_MULTU; inA = 32'd5; inB = 32'd7;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check_val("done_seen", seen, 1);
        check_val("busy_hold", busy_bad, 0);
        if (seen) begin
            check_val("latency", cyc, 34);
            check_val("busy_at_done", busy, 0);
            if (sb_q.size() > 0) begin
                r = sb_q.pop_front();
                check_val("hi", hi, r.hi);
                check_val("lo", lo, r.lo);
                m_hi = r.hi; m_lo = r.lo;
            end
        end
    endtask

    // Confirm no done pulse appears over n cycles.
    task automatic expect_quiet(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_val(tag, pulses, 0);
    endtask

    // Single-cycle op in IDLE (MTHI/MTLO/NOP), optionally with cancel.
    task automatic quick_op(input logic [2:0] o, input logic [31:0] a, input logic c);
        start = 1'b1; op = o; inA = a; cancel = c;
        if (!c && o == MDU_OP_MTHI) m_hi = a;
        if (!c && o == MDU_OP_MTLO) m_lo = a;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check_val("q_hi", hi, m_hi);
        check_val("q_lo", lo, m_lo);
        check_val("q_busy", busy, 0);
        check_val("q_done", done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; inA = 32'd0; inB = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        #12;
        check_val("rst_busy0", busy, 0);
        check_val("rst_done0", done, 0);
        check_val("rst_hi0", hi, 0);
        check_val("rst_lo0", lo, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(MDU_OP_MULT,  32'hFFFF_FFFF, 32'h0000_0005, -1, -1, -1);
        run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
        run_op(MDU_OP_MULTU, 32'd3,         32'd4,         -1, -1, -1);
        @(negedge clk);
        run_op(MDU_OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, -1, -1, -1);
        run_op(MDU_OP_DIVU,  32'd7,         32'd2,         -1, -1, -1);
        run_op(MDU_OP_DIV,   32'h0000_0064, 32'd0,         -1, -1, -1);
        run_op(MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
        run_op(MDU_OP_DIV,   32'h0000_0011, 32'hFFFF_FFFB, -1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            run_op(3'(1 + (i % 4)), $urandom, $urandom_range(1, 32'h0001_FFFF), -1, -1, -1);
        end

        // start while busy must be ignored: one result, one done
        run_op(MDU_OP_DIVU, 32'd1000, 32'd7, 5, -1, -1);
        expect_quiet("poke_no_extra_done", 40);

        quick_op(MDU_OP_MTLO, 32'hCAFE_F00D, 1'b0);
        quick_op(MDU_OP_MTHI, 32'h1357_9BDF, 1'b0);
        quick_op(MDU_OP_MTHI, 32'hDEAD_BEEF, 1'b1);   // cancel wins over start
        quick_op(3'd7,        32'h5555_5555, 1'b0);   // 111 behaves as NOP
        quick_op(MDU_OP_NOP,  32'hAAAA_AAAA, 1'b0);

        // cancel at CALC cycle 10 (offset 11 from acceptance)
        run_op(MDU_OP_MULTU, 32'd12345, 32'd6789, -1, 11, -1);
        expect_quiet("cancel_no_done", 40);

        // async reset mid-CALC, then MTHI
        run_op(MDU_OP_DIVU, 32'hFFFF_0000, 32'd3, -1, -1, 15);
        @(negedge clk);
        quick_op(MDU_OP_MTHI, 32'h0000_1234, 1'b0);
        @(negedge clk);
        check_val("mthi_busy_later", busy, 0);
        check_val("mthi_hi_later", hi, 32'h0000_1234);

        // arithmetic still works after reset
        run_op(MDU_OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
